// File: rtl/event_debouncer.sv
// Button/sensor debouncer: 2-flop synchroniser, stability-qualifying FSM, registered EVENT/LEVEL.
// Optional hold-to-repeat enabled by defining DEBOUNCE_AUTO_REPEAT_EN. All state updates on the CLK falling edge.
module event_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_CYCLES = 32,
    parameter int RPT_W         = 8
) (
    input  logic       CLK,
    input  logic       CLEAR,
    input  logic       BTN_IN,
    output logic       EVENT,
    output logic       LEVEL,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject configurations whose counters cannot hold the programmed intervals.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_stable
        $error("event_debouncer: STABLE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_DELAY < 1 || REPEAT_CYCLES < 1 ||
        REPEAT_DELAY > (2**RPT_W) - 1 || REPEAT_CYCLES > (2**RPT_W) - 1) begin : g_bad_repeat
        $error("event_debouncer: REPEAT_* out of range for RPT_W");
    end

    state_t           state;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    // rpt_phase=0 waits out the initial delay, rpt_phase=1 counts repeat periods.
    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_nxt;
    logic             rpt_phase;
    logic             rpt_hit;

    assign rcnt_nxt = rcnt + 1'b1;
    assign rpt_hit  = rpt_phase ? (rcnt_nxt == RPT_W'(REPEAT_CYCLES))
                                : (rcnt_nxt == RPT_W'(REPEAT_DELAY));
`endif

    assign STATE = state;

    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN_IN;
            s2 <= s1;
        end
    end

    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            state <= IDLE;
            cnt   <= '0;
            EVENT <= 1'b0;
            LEVEL <= 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            rcnt      <= '0;
            rpt_phase <= 1'b0;
`endif
        end else begin
            EVENT <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        EVENT <= 1'b1;
                        LEVEL <= 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        rcnt      <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        rcnt      <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        if (rpt_hit) begin
                            EVENT     <= 1'b1;
                            rcnt      <= '0;
                            rpt_phase <= 1'b1;
                        end else begin
                            rcnt <= rcnt_nxt;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to high resumes PRESSED silently; the repeat delay restarts.
                    if (s2) begin
                        state <= PRESSED;
                        cnt   <= '0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        rcnt      <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        LEVEL <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_debouncer.sv
// Bench for event_debouncer: directed test-plan steps plus random segments, checked against a
// run-length reference model of the debouncing rules.
module tb_event_debouncer;

    localparam int STABLE = 16;
    localparam int RD     = 64;
    localparam int RC     = 32;

    logic       CLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic       BTN_IN = 1'b0;
    logic       EVENT, LEVEL;
    logic [1:0] STATE;

    always #5 CLK = ~CLK;

    event_debouncer #(
        .STABLE_CYCLES(STABLE), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_CYCLES(RC), .RPT_W(8)
    ) dut (
        .CLK(CLK), .CLEAR(CLEAR), .BTN_IN(BTN_IN),
        .EVENT(EVENT), .LEVEL(LEVEL), .STATE(STATE)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: synchronised sample history summarised as value + run length.
    logic m_s1, m_s2, m_last, m_level, m_event;
    int   run, k;

    int   edge_n;
    int   dut_edges[$];
    int   fall_edge;
    logic prev_level;
    bit   level_dropped;
    int   div_cnt, div_pulses;

    function automatic logic [1:0] exp_state();
        return {m_level, m_level ^ m_last};
    endfunction

    task automatic m_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_last = 1'b0; m_level = 1'b0; m_event = 1'b0;
        run = 0; k = 0;
    endtask

    task automatic model_step(input logic b);
        logic v;
        logic was_pressed;
        v = m_s2;
        was_pressed = m_level && m_last;
        m_event = 1'b0;
        if (v == m_last) run++;
        else begin
            run = 1;
            m_last = v;
        end
        if (!m_level) begin
            if (v && run == STABLE) begin
                m_level = 1'b1;
                m_event = 1'b1;
                k = 0;
            end
        end else if (v) begin
            if (was_pressed) begin
                k++;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                if (k >= RD && (k - RD) % RC == 0) m_event = 1'b1;
`endif
            end else begin
                k = 0;
            end
        end else if (run == STABLE) begin
            m_level = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_edges(input string tag, input int exp[$]);
        check_int({tag, "_count"}, dut_edges.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_edges.size(); i++)
            check_int($sformatf("%s_edge%0d", tag, i), dut_edges[i], exp[i]);
    endtask

    // One clock: drive input after the rising edge, model the falling edge, sample at next rising edge.
    task automatic step(input logic b);
        BTN_IN = b;
        @(negedge CLK);
        model_step(b);
        edge_n++;
        @(posedge CLK);
        #1;
        check("EVENT", {1'b0, EVENT}, {1'b0, m_event});
        check("LEVEL", {1'b0, LEVEL}, {1'b0, m_level});
        check("STATE", STATE, exp_state());
        if (EVENT === 1'b1) begin
            dut_edges.push_back(edge_n);
            div_cnt++;
            if (div_cnt == 6) begin
                div_pulses++;
                div_cnt = 0;
            end
        end
        if (prev_level === 1'b1 && LEVEL === 1'b0) begin
            fall_edge = edge_n;
            level_dropped = 1'b1;
        end
        prev_level = LEVEL;
    endtask

    initial begin
        int e[$];
        m_reset();
        edge_n = 0; fall_edge = -1; prev_level = 1'b0; level_dropped = 1'b0;
        div_cnt = 0; div_pulses = 0;

        // Reset state
        #12;
        check("rst_EVENT", {1'b0, EVENT}, 2'd0);
        check("rst_LEVEL", {1'b0, LEVEL}, 2'd0);
        check("rst_STATE", STATE, 2'd0);
        @(posedge CLK);
        #1;
        CLEAR = 1'b1;

        // Clean press: event only at edge 18, level falls 18 edges after release
        edge_n = 0; dut_edges.delete();
        repeat (30) step(1'b1);
        repeat (30) step(1'b0);
        e.delete(); e.push_back(18);
        check_edges("clean", e);
        check_int("clean_fall", fall_edge, 48);

        // Bounce: 5-cycle toggles never qualify, final rise gives one event
        dut_edges.delete();
        for (int i = 0; i < 40; i++) step(((i / 5) % 2) == 0);
        check_int("bounce_quiet", dut_edges.size(), 0);
        edge_n = 0;
        repeat (30) step(1'b1);
        e.delete(); e.push_back(18);
        check_edges("bounce", e);
        repeat (30) step(1'b0);

        // Release glitch: back to PRESSED without a new event, LEVEL held
        edge_n = 0; dut_edges.delete();
        repeat (30) step(1'b1);
        dut_edges.delete(); level_dropped = 1'b0;
        repeat (10) step(1'b0);
        repeat (30) step(1'b1);
        check_int("glitch_events", dut_edges.size(), 0);
        check_int("glitch_level", int'(level_dropped), 0);
        repeat (30) step(1'b0);

        // Six presses feed a divide-by-6 counter
        dut_edges.delete(); div_cnt = 0; div_pulses = 0;
        repeat (6) begin
            repeat (20) step(1'b1);
            repeat (40) step(1'b0);
        end
        check_int("six_events", dut_edges.size(), 6);
        check_int("div6_pulses", div_pulses, 1);

        // Reset during PRESS_WAIT with input held high
        edge_n = 0;
        repeat (10) step(1'b1);
        check("pre_clear_STATE", STATE, 2'd1);
        CLEAR = 1'b0;
        #1;
        check("clr_STATE", STATE, 2'd0);
        check("clr_EVENT", {1'b0, EVENT}, 2'd0);
        check("clr_LEVEL", {1'b0, LEVEL}, 2'd0);
        m_reset();
        prev_level = 1'b0;
        @(posedge CLK);
        #1;
        CLEAR = 1'b1;
        edge_n = 0; dut_edges.delete();
        repeat (25) step(1'b1);
        e.delete(); e.push_back(18);
        check_edges("clear", e);
        repeat (30) step(1'b0);

        // Long hold
        edge_n = 0; dut_edges.delete();
        repeat (200) step(1'b1);
        repeat (40) step(1'b0);
        e.delete(); e.push_back(18);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        e.push_back(82); e.push_back(114); e.push_back(146); e.push_back(178);
`endif
        check_edges("hold", e);

        // Random segments checked cycle-by-cycle against the model
        for (int s = 0; s < 60; s++) begin
            logic v;
            int   len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            repeat (len) step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/event_debouncer.md
Name: event_debouncer

Overview:
- Conditions a raw, bouncing, asynchronous push-button or sensor line into clean single-cycle event strobes.
- Sits directly upstream of the divide-by-N event counter: EVENT is the count stimulus it consumes.
- Provides a synchroniser, a stability-qualifying FSM, a debounced level output and an optional hold-to-repeat function.

Parameters:
- STABLE_CYCLES, 16, number of consecutive identical synchronised samples needed to accept a press or release; legal range 2..(2^CNT_W - 1).
- CNT_W, 8, width of the stability counter.
- REPEAT_DELAY, 64, cycles in PRESSED before the first repeat EVENT; used only with the optional feature.
- REPEAT_CYCLES, 32, cycles between subsequent repeat EVENTs; used only with the optional feature.
- RPT_W, 8, width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_CYCLES).

Ports:
- CLK  input  1  system clock; all registers update on its falling edge.
- CLEAR  input  1  asynchronous, active-low reset.
- BTN_IN  input  1  raw input, active-high, asynchronous to CLK.
- EVENT  output  1  one-CLK-cycle strobe per accepted press (plus repeats when enabled).
- LEVEL  output  1  debounced button level.
- STATE  output  2  current FSM state, for debug.

Behaviour:
- Reset: CLEAR low forces, immediately and without waiting for a clock edge:
  - both synchroniser flops = 0
  - state = IDLE, stability counter = 0, repeat counter = 0
  - EVENT = 0, LEVEL = 0
- Synchroniser: two flops, s1 <= BTN_IN, s2 <= s1. The FSM samples only s2.
- FSM encoding: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
- IDLE: s2=1 -> PRESS_WAIT with cnt=1; otherwise stay, cnt=0.
- PRESS_WAIT:
  - s2=1 and cnt==STABLE_CYCLES-1 -> PRESSED; EVENT<=1, LEVEL<=1.
  - s2=1 otherwise -> cnt+1.
  - s2=0 -> IDLE, cnt=0, no EVENT.
- PRESSED:
  - s2=0 -> RELEASE_WAIT with cnt=1.
  - Otherwise stay, cnt=0.
- RELEASE_WAIT:
  - s2=0 and cnt==STABLE_CYCLES-1 -> IDLE; LEVEL<=0.
  - s2=0 otherwise -> cnt+1.
  - s2=1 -> PRESSED, cnt=0; no new EVENT, LEVEL stays 1.
- Outputs: EVENT and LEVEL are registered. EVENT is high for exactly one cycle and is forced 0 in every cycle it is not explicitly set.
- Latency: raw edge stable before falling edge 1 -> LEVEL/EVENT update at edge 2+STABLE_CYCLES. With the default, that is edge 18.
- Counter width: cnt never exceeds STABLE_CYCLES-1, so it never wraps.
- Back-to-back presses: a new press requires a full release qualification back to IDLE first.
- Reset mid-operation: any partial qualification is discarded. After CLEAR rises, an input that is already held high must requalify from IDLE and produces one EVENT.

Optional Feature:
- Macro: DEBOUNCE_AUTO_REPEAT_EN.
- Defined:
  - The repeat counter counts cycles spent in PRESSED, starting at 0 on entry.
  - EVENT pulses when the counter reaches REPEAT_DELAY, then every REPEAT_CYCLES while the FSM remains in PRESSED.
  - Entering RELEASE_WAIT clears the repeat counter. A bounce back into PRESSED restarts the REPEAT_DELAY interval and does not emit an immediate EVENT.
- Not defined:
  - The repeat counter and its logic are absent.
  - Exactly one EVENT per accepted press.
  - REPEAT_* parameters are ignored.

Test Plan:
- Clean press (STABLE_CYCLES=16): BTN_IN high from before edge 1, held 30 cycles then low -> EVENT high only between edges 18 and 19; LEVEL=1 from edge 18; LEVEL=0 at the 18th edge after the fall; no second EVENT.
- Bounce: BTN_IN toggles every 5 cycles for 40 cycles, then stays high -> no EVENT during bouncing; exactly one EVENT 18 edges after the final rise; STATE passes 1 then 2.
- Release glitch: in PRESSED, BTN_IN low for 10 cycles then high -> STATE goes 3 then back to 2; LEVEL stays 1; EVENT stays 0.
- Six clean presses separated by 40-cycle releases -> exactly 6 EVENT pulses; a downstream divide-by-6 counter produces one output pulse.
- CLEAR low while in PRESS_WAIT (cnt=8) with BTN_IN held high -> STATE=0 and EVENT=LEVEL=0 immediately; after CLEAR rises, EVENT at the 18th falling edge.
- With DEBOUNCE_AUTO_REPEAT_EN, defaults, BTN_IN held 200 cycles -> EVENTs at edges 18, 82, 114, 146, 178 (five total). Without the macro -> only edge 18.
